fmul_arbiter: RTL and testbench
===============================

# fmul_arbiter

Round-robin arbiter and sequencer that shares one FMUL32 multiplier between `NREQ` requesters. Each requester presents operands, opcode and rounding mode over a valid/ready handshake. The block grants one requester and drives the FMUL32 operand ports stable until `val` returns. It then delivers the result, tagged with the requester index, on a single response channel. It sits between client logic (sequencers, DPI-driven benches) and the FMUL32 instance; only one operation is in flight at a time.

## Interface
- `NREQ`, 4 — number of requesters, 2..16.
- `TIMEOUT`, 64 — WAIT-state cycle limit; used only with `FMUL_ARB_TIMEOUT_EN`.
- `IW` (localparam) = `$clog2(NREQ)`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  NREQ  — request pending, one bit per requester.
- `req_ready`  out  NREQ  — accept strobe, one-hot or zero.
- `req_op1`, `req_op2`  in  NREQ*32 each — packed operands; requester i occupies bits [32i+31:32i].
- `req_opc`  in  NREQ*2  — packed FMUL32 opcode per requester.
- `req_rmode`  in  NREQ*2  — packed rounding mode per requester.
- `rsp_valid`  out  1  — response available.
- `rsp_ready`  in  1  — consumer accepts response.
- `rsp_id`  out  IW  — index of the requester that owns the response.
- `rsp_result`  out  32  — FMUL32 result.
- `rsp_err`  out  1  — operation timed out.
- `fmul_op1`, `fmul_op2`  out  32 each — connect to FMUL32 `op1`/`op2`.
- `fmul_opc`  out  2  — connect to FMUL32 `opc`.
- `fmul_r_mode`  out  2  — connect to FMUL32 `r_mode`.
- `fmul_result`  in  32  — connect to FMUL32 `result`.
- `fmul_val`  in  1  — connect to FMUL32 `val`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **Reset:** state IDLE and all outputs 0. `last_grant` = NREQ-1, so requester 0 has first priority.
- **IDLE arbitration:**
  - The grant goes to the first requester with `req_valid` set, searching from `last_grant+1` with wrap-around mod NREQ.
  - `req_ready[g]` is asserted combinationally, only in IDLE, only for the granted requester.
  - On handshake the block registers op1, op2, opc and rmode of requester g onto the `fmul_*` ports, records g, updates `last_grant` to g and moves to ISSUE.
  - If no `req_valid` is set, the block stays in IDLE and `req_ready` is 0.
- **ISSUE:** one settle cycle with `fmul_*` stable; then WAIT.
- **WAIT:**
  - `fmul_*` is held.
  - On the first cycle with `fmul_val`=1, `fmul_result` is captured into `rsp_result`, `rsp_err` is set to 0 and the block moves to RESP.
- **RESP:**
  - `rsp_valid`=1; `rsp_id`, `rsp_result` and `rsp_err` are held stable.
  - On `rsp_ready`=1 the block deasserts `rsp_valid` and returns to IDLE.
- `fmul_*` outputs keep their last values outside WAIT; they never glitch to other requesters' data.
- `fmul_val` is ignored in IDLE, ISSUE and RESP.
- A requester may drop `req_valid` before being granted; this has no effect.
- Reset mid-operation aborts immediately. No response is produced, and no FMUL32 state is assumed.

## Timing
- Accept at cycle T, then ISSUE at T+1, then WAIT from T+2.
- If the first `fmul_val`=1 occurs at cycle W ≥ T+2, `rsp_valid` rises at W+1 (registered).
- Minimum latency from accept to `rsp_valid` is 3 cycles, for a combinational FMUL32.
- Earliest next accept is the cycle after the `rsp_valid`&`rsp_ready` handshake (IDLE).
- Peak throughput is one op per 4 cycles.
- `req_ready` depends combinationally on `req_valid`; there is no combinational path from `fmul_val` or `rsp_ready` to any output.

## Configuration
- **`FMUL_ARB_TIMEOUT_EN` defined:**
  - An 8..16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - If `TIMEOUT` WAIT cycles pass without `fmul_val`, the block enters RESP with `rsp_err`=1 and `rsp_result`=32'h7FC00000 (qNaN).
  - A `fmul_val` arriving on the terminal cycle wins: the result is taken and `rsp_err`=0.
- **Not defined:** no counter is built, WAIT waits indefinitely, `rsp_err` is constant 0 and `TIMEOUT` is unused.

## Test plan
- Reset, then req0 valid with op1=3F800000, op2=40000000, opc=0, FMUL model returning val 1 cycle after ISSUE → all outputs 0 during reset; `req_ready[0]` at T; `rsp_valid` at T+3 with `rsp_id`=0, `rsp_result`=40000000, `rsp_err`=0.
- All 4 `req_valid` held high, `rsp_ready`=1 → grant order 0,1,2,3,0; each `rsp_id` matches, and `fmul_op1` equals the granted requester's op1.
- `rsp_ready` held low 5 cycles in RESP → `rsp_valid`, `rsp_id` and `rsp_result` stable; all `req_ready`=0 until handshake.
- `rst_n` pulsed low during WAIT of req2 → all outputs 0 asynchronously, no response; after release, requester 0 is granted first.
- Spurious `fmul_val`=1 in IDLE and ISSUE, then real val in WAIT → only the WAIT-cycle result is returned.
- `FMUL_ARB_TIMEOUT_EN`, TIMEOUT=64, `fmul_val` never asserted → `rsp_valid` after 64 WAIT cycles with `rsp_err`=1 and `rsp_result`=7FC00000. Without the macro → the block stays in WAIT with `rsp_valid`=0 for 1000 cycles.

Source files
------------

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter/sequencer sharing one FMUL32 among NREQ requesters.
// Define FMUL_ARB_TIMEOUT_EN to build the WAIT-state timeout (qNaN + rsp_err).
module fmul_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int IW     = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_op1,
    input  logic [NREQ*32-1:0] req_op2,
    input  logic [NREQ*2-1:0]  req_opc,
    input  logic [NREQ*2-1:0]  req_rmode,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic [31:0]        rsp_result,
    output logic              rsp_err,
    output logic [31:0]        fmul_op1,
    output logic [31:0]        fmul_op2,
    output logic [1:0]         fmul_opc,
    output logic [1:0]         fmul_r_mode,
    input  logic [31:0]        fmul_result,
    input  logic              fmul_val
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t        state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant_idx;
    logic [IW-1:0] cand;
    logic          grant_found;

`ifdef FMUL_ARB_TIMEOUT_EN
    localparam int TCW_RAW = $clog2(TIMEOUT + 1);
    localparam int TCW     = (TCW_RAW < 8) ? 8 : ((TCW_RAW > 16) ? 16 : TCW_RAW);
    logic [TCW-1:0] wait_cnt;
`else
    assign rsp_err = 1'b0;
`endif

    // First valid requester at or after last_grant+1, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IW'((32'(last_grant) + 32'd1 + k) % 32'(NREQ));
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Gated by rst_n so every output reads zero while reset is held.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == ST_IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= IW'(NREQ - 1);
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_result  <= '0;
            fmul_op1    <= '0;
            fmul_op2    <= '0;
            fmul_opc    <= '0;
            fmul_r_mode <= '0;
`ifdef FMUL_ARB_TIMEOUT_EN
            rsp_err     <= 1'b0;
            wait_cnt    <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        fmul_op1    <= req_op1[32*grant_idx +: 32];
                        fmul_op2    <= req_op2[32*grant_idx +: 32];
                        fmul_opc    <= req_opc[2*grant_idx +: 2];
                        fmul_r_mode <= req_rmode[2*grant_idx +: 2];
                        rsp_id      <= grant_idx;
                        last_grant  <= grant_idx;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
`ifdef FMUL_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (fmul_val) begin
                        rsp_result <= fmul_result;
`ifdef FMUL_ARB_TIMEOUT_EN
                        rsp_err    <= 1'b0;
`endif
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
`ifdef FMUL_ARB_TIMEOUT_EN
                    end else if (wait_cnt == TCW'(TIMEOUT - 1)) begin
                        rsp_result <= 32'h7FC0_0000;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= 1'b1;
                        state      <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Directed bench for fmul_arbiter with a small FMUL32 stand-in that answers
// one cycle after ISSUE; timeout checks follow FMUL_ARB_TIMEOUT_EN.
module tb_fmul_arbiter;
    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_op1, req_op2;
    logic [NREQ*2-1:0]  req_opc, req_rmode;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [IW-1:0]      rsp_id;
    logic [31:0]        rsp_result;
    logic [31:0]        fmul_op1, fmul_op2, fmul_result;
    logic [1:0]         fmul_opc, fmul_r_mode;
    logic              fmul_val;

    int checks = 0;
    int errors = 0;
    logic model_en = 1'b0;
    int   model_dly = 0;

    logic [31:0] op1_tab [NREQ];
    logic [31:0] op2_tab [NREQ];
    logic [1:0]  opc_tab [NREQ];
    logic [1:0]  rm_tab  [NREQ];

    fmul_arbiter #(.NREQ(NREQ), .TIMEOUT(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1(req_op1), .req_op2(req_op2), .req_opc(req_opc), .req_rmode(req_rmode),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .fmul_op1(fmul_op1), .fmul_op2(fmul_op2), .fmul_opc(fmul_opc),
        .fmul_r_mode(fmul_r_mode), .fmul_result(fmul_result), .fmul_val(fmul_val)
    );

    always #5 clk = ~clk;

    // Stand-in multiplier: exact for 1.0*x, a fixed scramble otherwise.
    function automatic logic [31:0] fake_mul(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h3F80_0000) return b;
        return a ^ b ^ 32'h1234_5678;
    endfunction

    initial begin
        fmul_val    = 1'b0;
        fmul_result = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) model_dly = 0;
            else if (model_en && (req_valid & req_ready) != '0) model_dly = 2;
            @(posedge clk);
            #1;
            if (model_en) begin
                fmul_val = 1'b0;
                if (model_dly > 0) begin
                    model_dly--;
                    if (model_dly == 0) begin
                        fmul_val    = 1'b1;
                        fmul_result = fake_mul(fmul_op1, fmul_op2);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_op1[32*i +: 32] = op1_tab[i];
            req_op2[32*i +: 32] = op2_tab[i];
            req_opc[2*i +: 2]   = opc_tab[i];
            req_rmode[2*i +: 2] = rm_tab[i];
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (req_ready == '0 && n < 20) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_rsp(inout int lat);
        while (rsp_valid !== 1'b1 && lat < 20) begin
            cyc();
            lat++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) begin
            op1_tab[i] = 32'hA000_0000 + i; op2_tab[i] = 32'hB000_0000 + i;
            opc_tab[i] = 2'b11; rm_tab[i] = 2'b10;
        end
        load_ops();
        rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b1; model_en = 1'b0;
        repeat (3) cyc();
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got %h want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (rsp_id !== '0) begin errors++; $display("FAIL reset_rsp_id got %h want 0", rsp_id); end
        checks++; if (rsp_result !== '0) begin errors++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
        checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
        checks++; if ({fmul_op1, fmul_op2, fmul_opc, fmul_r_mode} !== '0) begin
            errors++; $display("FAIL reset_fmul_ports got %h %h %h %h want 0", fmul_op1, fmul_op2, fmul_opc, fmul_r_mode);
        end
        req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL idle_no_req got %h want 0", req_ready); end
    endtask

    task automatic test_single();
        op1_tab[0] = 32'h3F80_0000; op2_tab[0] = 32'h4000_0000; opc_tab[0] = 2'b00; rm_tab[0] = 2'b01;
        load_ops();
        model_en = 1'b1; rsp_ready = 1'b0; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant got %b want 0001", req_ready); end
        cyc(); req_valid = '0;
        checks++; if (rsp_valid !== 1'b0 || fmul_op1 !== 32'h3F80_0000 || fmul_op2 !== 32'h4000_0000
                      || fmul_opc !== 2'b00 || fmul_r_mode !== 2'b01) begin
            errors++; $display("FAIL single_issue got v=%b op1=%h op2=%h opc=%b rm=%b", rsp_valid, fmul_op1, fmul_op2, fmul_opc, fmul_r_mode);
        end
        cyc();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp got %b want 0", rsp_valid); end
        cyc();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'h4000_0000 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL single_rsp got v=%b id=%0d res=%h err=%b want 1 0 40000000 0", rsp_valid, rsp_id, rsp_result, rsp_err);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int n;
        int lat;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            op1_tab[i] = 32'h4000_0000 + 32'(i) * 32'h0011_0000;
            op2_tab[i] = 32'h3F00_0000 + 32'(i);
            opc_tab[i] = 2'(i); rm_tab[i] = 2'(3 - i);
        end
        load_ops();
        model_en = 1'b1; rsp_ready = 1'b1; req_valid = '1;
        #1;
        for (int k = 0; k < 5; k++) begin
            int exp_id;
            exp_id = k % NREQ;
            wait_ready(n);
            checks++; if (req_ready !== 4'(1 << exp_id)) begin
                errors++; $display("FAIL rr_grant op%0d got %b want %b", k, req_ready, 4'(1 << exp_id));
            end
            cyc();
            lat = 1;
            checks++; if (fmul_op1 !== op1_tab[exp_id] || fmul_op2 !== op2_tab[exp_id] || fmul_opc !== opc_tab[exp_id]) begin
                errors++; $display("FAIL rr_fmul_ops op%0d got %h %h %b want %h %h %b", k, fmul_op1, fmul_op2, fmul_opc,
                                   op1_tab[exp_id], op2_tab[exp_id], opc_tab[exp_id]);
            end
            wait_rsp(lat);
            checks++; if (lat != 3) begin errors++; $display("FAIL rr_latency op%0d got %0d want 3", k, lat); end
            checks++; if (rsp_id !== IW'(exp_id) || rsp_result !== fake_mul(op1_tab[exp_id], op2_tab[exp_id])) begin
                errors++; $display("FAIL rr_rsp op%0d got id=%0d res=%h want id=%0d res=%h", k, rsp_id, rsp_result,
                                   exp_id, fake_mul(op1_tab[exp_id], op2_tab[exp_id]));
            end
            cyc();
        end
        req_valid = '0; rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n;
        int lat;
        logic [31:0] exp_res;
        exp_res = fake_mul(op1_tab[2], op2_tab[2]);
        rsp_ready = 1'b0; req_valid = 4'b0100;
        #1;
        wait_ready(n);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b want 0100", req_ready); end
        cyc(); req_valid = '1;
        lat = 1;
        wait_rsp(lat);
        for (int k = 0; k < 5; k++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== exp_res || req_ready !== '0) begin
                errors++; $display("FAIL bp_hold cyc%0d got v=%b id=%0d res=%h rdy=%b want 1 2 %h 0000", k, rsp_valid, rsp_id,
                                   rsp_result, req_ready, exp_res);
            end
            cyc();
        end
        rsp_ready = 1'b1; req_valid = '0;
        cyc();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release got %b want 0", rsp_valid); end
    endtask

    task automatic test_reset_mid();
        int n;
        int lat;
        model_en = 1'b0; fmul_val = 1'b0; rsp_ready = 1'b0; req_valid = 4'b0100;
        #1;
        wait_ready(n);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rst_mid_grant got %b want 0100", req_ready); end
        cyc(); req_valid = '0;
        cyc();
        cyc();
        #2;
        rst_n = 1'b0; req_valid = '1;
        #1;
        checks++; if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_result !== '0 || rsp_err !== 1'b0
                      || {fmul_op1, fmul_op2, fmul_opc, fmul_r_mode} !== '0) begin
            errors++; $display("FAIL rst_mid_async got rdy=%b v=%b id=%0d res=%h op1=%h want all 0", req_ready, rsp_valid,
                               rsp_id, rsp_result, fmul_op1);
        end
        cyc();
        rst_n = 1'b1; model_en = 1'b1; rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_first_grant got rdy=%b v=%b want 0001 0", req_ready, rsp_valid);
        end
        cyc(); req_valid = '0;
        lat = 1;
        wait_rsp(lat);
        checks++; if (lat != 3 || rsp_id !== 2'd0 || rsp_result !== fake_mul(op1_tab[0], op2_tab[0])) begin
            errors++; $display("FAIL rst_mid_rsp got lat=%0d id=%0d res=%h want 3 0 %h", lat, rsp_id, rsp_result,
                               fake_mul(op1_tab[0], op2_tab[0]));
        end
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic test_spurious();
        int n;
        model_en = 1'b0; rsp_ready = 1'b0; req_valid = 4'b0010;
        fmul_val = 1'b1; fmul_result = 32'hDEAD_BEEF;
        #1;
        wait_ready(n);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL spur_grant got %b want 0010", req_ready); end
        cyc(); req_valid = '0; fmul_val = 1'b1; fmul_result = 32'hCAFE_F00D;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL spur_idle_val got v=%b want 0", rsp_valid); end
        cyc(); fmul_val = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL spur_issue_val got v=%b want 0", rsp_valid); end
        cyc(); fmul_val = 1'b1; fmul_result = 32'h1234_5678;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL spur_wait_idle got v=%b want 0", rsp_valid); end
        cyc(); fmul_val = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_result !== 32'h1234_5678 || rsp_id !== 2'd1 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL spur_rsp got v=%b res=%h id=%0d err=%b want 1 12345678 1 0", rsp_valid, rsp_result, rsp_id, rsp_err);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        model_en = 1'b0; fmul_val = 1'b0; rsp_ready = 1'b0; req_valid = 4'b1000;
        #1;
        wait_ready(n);
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL to_grant got %b want 1000", req_ready); end
        cyc(); req_valid = '0;
`ifdef FMUL_ARB_TIMEOUT_EN
        n = 1;
        while (n < 65) begin
            cyc();
            n++;
        end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL to_early got v=%b want 0", rsp_valid); end
        cyc();
        checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 32'h7FC0_0000 || rsp_id !== 2'd3) begin
            errors++; $display("FAIL to_rsp got v=%b err=%b res=%h id=%0d want 1 1 7fc00000 3", rsp_valid, rsp_err, rsp_result, rsp_id);
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
`else
        n = 0;
        for (int k = 0; k < 1000; k++) begin
            cyc();
            if (rsp_valid !== 1'b0) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL no_to_wait got %0d valid cycles want 0", n); end
        checks++; if (fmul_op1 !== op1_tab[3] || rsp_err !== 1'b0) begin
            errors++; $display("FAIL no_to_hold got op1=%h err=%b want %h 0", fmul_op1, rsp_err, op1_tab[3]);
        end
`endif
    endtask

    initial begin
        req_valid = '0; rsp_ready = 1'b0;
        req_op1 = '0; req_op2 = '0; req_opc = '0; req_rmode = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_spurious();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
